// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU with a bit-serial shifter.
//
// Logic/arithmetic ops finish one cycle after acceptance. Shift and rotate
// ops load the operand and then move it one bit per cycle, k = b[SHW-1:0]
// times. The result is held in DONE until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation presented on a/b/op
//   in_ready   block is IDLE and will accept an operation
//   a, b       operands; b[SHW-1:0] is the shift amount for shift ops
//   op         0 AND, 1 XOR, 2 NAND, 3 OR, 4 NOT a, 5 NOR, 6 -a, 7 XNOR,
//              8 ADD, 9 SUB, 10 SLL, 11 SRL, 12 SRA, 13 ROL, 14 ROR, 15 -> 0
//   out_valid  res holds a completed result
//   out_ready  consumer takes the result
//   res        registered result
//   flags      {N, Z, C, V}, registered with res (only with SEQ_ALU_FLAGS_EN)
//   busy       high whenever the block is not IDLE
//
// Build option: define SEQ_ALU_FLAGS_EN to add the flags port and the
// carry/overflow logic.

module seq_alu #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
`ifdef SEQ_ALU_FLAGS_EN
    output logic [3:0]       flags,
`endif
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,  OP_XOR  = 4'd1,  OP_NAND = 4'd2,  OP_OR   = 4'd3,
        OP_NOTA = 4'd4,  OP_NOR  = 4'd5,  OP_NEG  = 4'd6,  OP_XNOR = 4'd7,
        OP_ADD  = 4'd8,  OP_SUB  = 4'd9,  OP_SLL  = 4'd10, OP_SRL  = 4'd11,
        OP_SRA  = 4'd12, OP_ROL  = 4'd13, OP_ROR  = 4'd14, OP_INV  = 4'd15
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    op_t              op_in;
    op_t              sop;          // shift op captured at acceptance
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   k_in;
    logic             accept;
    logic             is_shift_in;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_r;
    logic [WIDTH-1:0] sh_r;

    assign op_in       = op_t'(op);
    assign k_in        = b[SHW-1:0];
    assign accept      = in_valid & in_ready;
    assign is_shift_in = (op_in == OP_SLL) || (op_in == OP_SRL) ||
                         (op_in == OP_SRA) || (op_in == OP_ROL) ||
                         (op_in == OP_ROR);
    assign diff        = a - b;

`ifdef SEQ_ALU_FLAGS_EN
    logic [WIDTH:0] sum_x;
    logic           add_c, add_v, sub_c, sub_v;
    logic [3:0]     alu_f;
    logic           sh_c;

    assign sum_x = {1'b0, a} + {1'b0, b};
    assign sum   = sum_x[WIDTH-1:0];
    assign add_c = sum_x[WIDTH];
    assign sub_c = (a < b);
    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
    // result sign differs from a.
    assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    // Bit leaving the register on this shift step.
    assign sh_c  = ((sop == OP_SLL) || (sop == OP_ROL)) ? res[WIDTH-1] : res[0];
`else
    assign sum = a + b;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept)
                       state_n = (is_shift_in && (k_in != '0)) ? SHIFT : DONE;
            SHIFT: if (cnt == SHW'(1)) state_n = DONE;
            DONE:  if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        alu_r = '0;
        case (op_in)
            OP_AND:  alu_r = a & b;
            OP_XOR:  alu_r = a ^ b;
            OP_NAND: alu_r = ~(a & b);
            OP_OR:   alu_r = a | b;
            OP_NOTA: alu_r = ~a;
            OP_NOR:  alu_r = ~(a | b);
            OP_NEG:  alu_r = ~a + WIDTH'(1);
            OP_XNOR: alu_r = ~(a ^ b);
            OP_ADD:  alu_r = sum;
            OP_SUB:  alu_r = diff;
            default: alu_r = '0;
        endcase
    end

`ifdef SEQ_ALU_FLAGS_EN
    always_comb begin
        alu_f = {alu_r[WIDTH-1], (alu_r == '0), 1'b0, 1'b0};
        if (op_in == OP_ADD) alu_f[1:0] = {add_c, add_v};
        if (op_in == OP_SUB) alu_f[1:0] = {sub_c, sub_v};
    end
`endif

    // ---------------- one-bit shift/rotate step ----------------
    always_comb begin
        sh_r = res;
        case (sop)
            OP_SLL:  sh_r = {res[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_r = {1'b0, res[WIDTH-1:1]};
            OP_SRA:  sh_r = {res[WIDTH-1], res[WIDTH-1:1]};
            OP_ROL:  sh_r = {res[WIDTH-2:0], res[WIDTH-1]};
            OP_ROR:  sh_r = {res[0], res[WIDTH-1:1]};
            default: sh_r = res;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res   <= '0;
            cnt   <= '0;
            sop   <= OP_AND;
`ifdef SEQ_ALU_FLAGS_EN
            flags <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (is_shift_in) begin
                        res <= a;
                        cnt <= k_in;
                        sop <= op_in;
`ifdef SEQ_ALU_FLAGS_EN
                        flags <= {a[WIDTH-1], (a == '0), 1'b0, 1'b0};
`endif
                    end else begin
                        res <= alu_r;
`ifdef SEQ_ALU_FLAGS_EN
                        flags <= alu_f;
`endif
                    end
                end
                SHIFT: begin
                    res <= sh_r;
                    cnt <= cnt - SHW'(1);
`ifdef SEQ_ALU_FLAGS_EN
                    flags <= {sh_r[WIDTH-1], (sh_r == '0), sh_c, 1'b0};
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
